// File: rtl/store_buffer.sv
// store_buffer: aligns sb/sh/sw store data onto byte lanes, builds byte
// enables and queues the writes in a DEPTH-entry circular FIFO that drains
// to the data-memory write port over a req/ack handshake.
//
// Optional build macro: STORE_MISALIGN_TRAP_EN
//   defined   - misaligned half/word stores complete the handshake, are
//               dropped, and raise a one-cycle st_misalign pulse.
//   undefined - low address bits below the access size are ignored and
//               every handshaked store is enqueued; st_misalign is 0.
//
// Store width encoding (matches the MEM stage declarations):
//   2'b00 = byte, 2'b01 = half, 2'b10 = word, 2'b11 = treated as word.

module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_mode,
    output logic                     st_misalign,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] MEM_op_byte = 2'b00;
    localparam logic [1:0] MEM_op_half = 2'b01;
    localparam logic [1:0] MEM_op_word = 2'b10;

    // ------------------------------------------------------------------
    // Pointer / occupancy state
    // ------------------------------------------------------------------
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    // Entry storage: word address, lane-aligned data, byte enables.
    // No reset on the array; validity is tracked purely by count_q.
    logic [29:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [3:0]  be_mem   [DEPTH];

    // Aligned view of the incoming store
    logic [3:0]  al_be;
    logic [31:0] al_wdata;

    // Handshake qualifiers
    logic push;
    logic pop;
    logic enq;

    // Head-of-queue raw read
    logic [29:0] head_addr;
    logic [31:0] head_data;
    logic [3:0]  head_be;

    // ------------------------------------------------------------------
    // Status derived only from registered occupancy, so st_ready has no
    // combinational path from mem_ack or st_valid.
    // ------------------------------------------------------------------
    assign st_ready = (count_q != CW'(DEPTH));
    assign mem_req  = (count_q != '0);
    assign busy     = (count_q != '0);
    assign count    = count_q;

    assign push = st_valid & st_ready;
    // An ack while empty is ignored because mem_req gates it.
    assign pop  = mem_req & mem_ack;

    // Little-endian lane steering and byte-enable generation
    always_comb begin
        al_be    = 4'b1111;
        al_wdata = st_data;
        case (st_mode)
            MEM_op_byte: begin
                al_be    = 4'b0001 << st_addr[1:0];
                al_wdata = {4{st_data[7:0]}};
            end
            MEM_op_half: begin
                al_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                al_wdata = {2{st_data[15:0]}};
            end
            MEM_op_word: begin
                al_be    = 4'b1111;
                al_wdata = st_data;
            end
            default: begin
                al_be    = 4'b1111;
                al_wdata = st_data;
            end
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    logic al_misaligned;
    logic misalign_q, misalign_d;

    // Detect a store whose address is not a multiple of its access size
    always_comb begin
        al_misaligned = 1'b0;
        case (st_mode)
            MEM_op_byte: al_misaligned = 1'b0;
            MEM_op_half: al_misaligned = st_addr[0];
            default:     al_misaligned = |st_addr[1:0];
        endcase
    end

    // A misaligned store is accepted on the handshake but never enqueued
    assign enq        = push & ~al_misaligned;
    assign misalign_d = push & al_misaligned;

    // One-cycle registered misalignment pulse after the accepting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign st_misalign = misalign_q;
`else
    // Every handshaked store is enqueued; alignment is implied by lanes.
    assign enq         = push;
    assign st_misalign = 1'b0;
`endif

    // Next-state for pointers and occupancy
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (enq) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all queued entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-entry write ports: each slot captures the aligned store when the
    // write pointer selects it.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the aligned store into this slot on enqueue
            always_ff @(posedge clk) begin
                if (enq && (wptr_q == PW'(gi))) begin
                    addr_mem[gi] <= st_addr[31:2];
                    data_mem[gi] <= al_wdata;
                    be_mem[gi]   <= al_be;
                end
            end
        end
    endgenerate

    // Head entry read; stays stable while the request waits for an ack
    // because rptr_q only moves on a pop.
    assign head_addr = addr_mem[rptr_q];
    assign head_data = data_mem[rptr_q];
    assign head_be   = be_mem[rptr_q];

    // Write-port outputs, forced to zero whenever nothing is requested
    always_comb begin
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_be    = 4'h0;
        if (mem_req) begin
            mem_addr  = {head_addr, 2'b00};
            mem_wdata = head_data;
            mem_be    = head_be;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a scoreboard queue of expected
// memory writes is filled as stores are handshaked and checked against the
// head outputs every cycle. Honours STORE_MISALIGN_TRAP_EN like the design.

module tb_store_buffer;

    localparam int DEPTH = 4;

    localparam logic [1:0] M_B = 2'b00;
    localparam logic [1:0] M_H = 2'b01;
    localparam logic [1:0] M_W = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_mode;
    logic        st_misalign;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        busy;
    logic [2:0]  count;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_mode    (st_mode),
        .st_misalign(st_misalign),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .busy       (busy),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic wr_t model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
        wr_t w;
        w.addr = {a[31:2], 2'b00};
        case (m)
            M_B: begin
                w.be    = 4'b0001 << a[1:0];
                w.wdata = {4{d[7:0]}};
            end
            M_H: begin
                w.be    = a[1] ? 4'b1100 : 4'b0011;
                w.wdata = {2{d[15:0]}};
            end
            default: begin
                w.be    = 4'b1111;
                w.wdata = d;
            end
        endcase
        return w;
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [1:0] m);
`ifdef STORE_MISALIGN_TRAP_EN
        if (m == M_B) return 1'b0;
        if (m == M_H) return a[0];
        return |a[1:0];
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard update on each handshake edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (mem_req && mem_ack && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (st_valid && st_ready && !is_mis(st_addr, st_mode))
                exp_q.push_back(model(st_addr, st_data, st_mode));
        end
    end

    // Compare head outputs and status against the scoreboard mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            check_val("count", 32'(count), 32'(exp_q.size()));
            check_val("st_ready", 32'(st_ready), 32'(exp_q.size() != DEPTH));
            check_val("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_req", 32'(mem_req), 32'h0);
                end else begin
                    check_val("head_addr", mem_addr, exp_q[0].addr);
                    check_val("head_wdata", mem_wdata, exp_q[0].wdata);
                    check_val("head_be", 32'(mem_be), 32'(exp_q[0].be));
                end
            end else begin
                check_val("idle_addr", mem_addr, 32'h0);
                check_val("idle_wdata", mem_wdata, 32'h0);
                check_val("idle_be", 32'(mem_be), 32'h0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
        int n;
        n = 0;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_mode  = m;
        while (!st_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (!st_ready) check_val("store_timeout", 32'(st_ready), 32'h1);
        tick(1);
        st_valid = 1'b0;
        $display("[TB] store addr=0x%08h data=0x%08h mode=%0d count=%0d", a, d, m, count);
    endtask

    task automatic drain();
        int n;
        n = 0;
        mem_ack = 1'b1;
        while (count != 0 && n < 50) begin
            tick(1);
            n++;
        end
        mem_ack = 1'b0;
        check_val("drain_done", 32'(count), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_mode  = M_W;
        mem_ack  = 1'b0;
        #1 rst   = 1'b1;
        #1;
        // Reset state
        check_val("rst_mem_req", 32'(mem_req), 32'h0);
        check_val("rst_count", 32'(count), 32'h0);
        check_val("rst_st_ready", 32'(st_ready), 32'h1);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_misalign", 32'(st_misalign), 32'h0);
        check_val("rst_be", 32'(mem_be), 32'h0);
        check_val("rst_addr", mem_addr, 32'h0);
        check_val("rst_wdata", mem_wdata, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Byte store, ack low: head appears next cycle and holds
        do_store(32'h0000_1003, 32'h0000_00AB, M_B);
        check_val("sb_req", 32'(mem_req), 32'h1);
        check_val("sb_addr", mem_addr, 32'h0000_1000);
        check_val("sb_be", 32'(mem_be), 32'h8);
        check_val("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        tick(3);
        check_val("sb_hold_addr", mem_addr, 32'h0000_1000);
        check_val("sb_hold_be", 32'(mem_be), 32'h8);
        check_val("sb_hold_wdata", mem_wdata, 32'hABAB_ABAB);
        drain();

        // Half store
        do_store(32'h0000_2002, 32'h1234_CAFE, M_H);
        check_val("sh_addr", mem_addr, 32'h0000_2000);
        check_val("sh_be", 32'(mem_be), 32'hC);
        check_val("sh_wdata", mem_wdata, 32'hCAFE_CAFE);
        drain();

        // All byte lanes, low half, and the spare mode value
        for (int i = 0; i < 4; i++)
            do_store(32'h0000_4000 + 32'(i), 32'h0000_0011 * 32'(i + 1), M_B);
        drain();
        do_store(32'h0000_5000, 32'h0000_BEEF, M_H);
        do_store(32'h0000_5004, 32'h89AB_CDEF, 2'b11);
        drain();

        // Fill and drain
        for (int i = 0; i < DEPTH; i++)
            do_store(32'h0000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), M_W);
        check_val("full_count", 32'(count), 32'h4);
        check_val("full_ready", 32'(st_ready), 32'h0);
        st_valid = 1'b1;
        st_addr  = 32'h0000_0200;
        st_data  = 32'hBEEF_0005;
        st_mode  = M_W;
        tick(2);
        check_val("stall_count", 32'(count), 32'h4);
        check_val("stall_head", mem_addr, 32'h0000_0100);
        mem_ack = 1'b1;
        tick(1);
        check_val("after_pop_ready", 32'(st_ready), 32'h1);
        check_val("after_pop_count", 32'(count), 32'h3);
        check_val("after_pop_head", mem_addr, 32'h0000_0104);
        tick(1);
        st_valid = 1'b0;
        check_val("push_pop_full_count", 32'(count), 32'h3);
        drain();

        // Simultaneous push and pop at count 2
        do_store(32'h0000_0600, 32'h6000_0000, M_W);
        do_store(32'h0000_0604, 32'h6000_0004, M_W);
        check_val("pp_count_before", 32'(count), 32'h2);
        st_valid = 1'b1;
        st_addr  = 32'h0000_0608;
        st_data  = 32'h6000_0008;
        st_mode  = M_W;
        mem_ack  = 1'b1;
        tick(1);
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        check_val("pp_count", 32'(count), 32'h2);
        check_val("pp_head", mem_addr, 32'h0000_0604);
        drain();

        // Back-to-back stores with ack held high
        mem_ack  = 1'b1;
        st_valid = 1'b1;
        st_mode  = M_W;
        for (int i = 0; i < 6; i++) begin
            st_addr = 32'h0000_0800 + 32'(4 * i);
            st_data = 32'hC000_0000 + 32'(i);
            tick(1);
            check_val("stream_ready", 32'(st_ready), 32'h1);
        end
        st_valid = 1'b0;
        check_val("stream_count", 32'(count), 32'h1);
        drain();

        // Ack while empty is ignored
        mem_ack = 1'b1;
        tick(2);
        check_val("empty_ack_count", 32'(count), 32'h0);
        check_val("empty_ack_req", 32'(mem_req), 32'h0);
        mem_ack = 1'b0;

        // Reset mid-drain, no clock edge between assert and check
        for (int i = 0; i < 3; i++)
            do_store(32'h0000_0700 + 32'(4 * i), 32'h7000_0000 + 32'(i), M_W);
        check_val("pre_rst_count", 32'(count), 32'h3);
        check_val("pre_rst_req", 32'(mem_req), 32'h1);
        mem_ack = 1'b1;
        #1 rst = 1'b1;
        #1;
        check_val("async_rst_req", 32'(mem_req), 32'h0);
        check_val("async_rst_be", 32'(mem_be), 32'h0);
        check_val("async_rst_count", 32'(count), 32'h0);
        mem_ack = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_val("post_rst_ready", 32'(st_ready), 32'h1);

        // Misaligned word store
        do_store(32'h0000_3001, 32'hDEAD_BEEF, M_W);
`ifdef STORE_MISALIGN_TRAP_EN
        check_val("mis_pulse", 32'(st_misalign), 32'h1);
        check_val("mis_count", 32'(count), 32'h0);
        tick(1);
        check_val("mis_pulse_end", 32'(st_misalign), 32'h0);
        do_store(32'h0000_3003, 32'h0000_1234, M_H);
        check_val("mis_half_pulse", 32'(st_misalign), 32'h1);
        check_val("mis_half_count", 32'(count), 32'h0);
        do_store(32'h0000_3002, 32'h0000_5678, M_H);
        check_val("al_half_misalign", 32'(st_misalign), 32'h0);
        check_val("al_half_count", 32'(count), 32'h1);
        drain();
`else
        check_val("mis_addr", mem_addr, 32'h0000_3000);
        check_val("mis_be", 32'(mem_be), 32'hF);
        check_val("mis_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_val("mis_flag", 32'(st_misalign), 32'h0);
        drain();
`endif

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store-side counterpart to the load-path memory extender. It sits between the MEM stage and the data-memory write port. It accepts `sb`/`sh`/`sw` requests, aligns the store data onto byte lanes, generates byte enables, and queues the writes in a small FIFO. The FIFO drains to memory over a req/ack handshake, so the pipeline stalls on stores only when the FIFO is full.

## Interface
Parameters:
- `DEPTH`, 4: number of FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `st_valid`  in  1  the MEM stage presents a store.
- `st_ready`  out  1  the buffer can accept a store this cycle.
- `st_addr`  in  32  byte address of the store.
- `st_data`  in  32  R[rt], right-justified.
- `st_mode`  in  2  store width: `MEM_op_byte`, `MEM_op_half` or `MEM_op_word` (declarations.v).
- `st_misalign`  out  1  one-cycle pulse: a misaligned store was dropped.
- `mem_req`  out  1  head entry valid; write requested.
- `mem_ack`  in  1  memory has accepted the head write.
- `mem_addr`  out  32  word address of the head entry; bits [1:0] always 0.
- `mem_wdata`  out  32  lane-aligned write data.
- `mem_be`  out  4  byte enables; bit i covers `mem_wdata[8i+7:8i]`.
- `busy`  out  1  buffer is non-empty; used for drain before syscall/fence.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: circular array of {addr[31:2], wdata, be}. Write pointer, read pointer, count.
- Push: on `st_valid && st_ready`, the aligned entry is written at wptr, and wptr increments modulo DEPTH.
- Pop: on `mem_req && mem_ack`, rptr increments modulo DEPTH.
- Count behaviour:
  - Push and pop in the same cycle: count unchanged.
  - Pop only: count−1.
  - Push only: count+1.
- Lane alignment is little-endian. `a` = `st_addr[1:0]`.
  - Byte: be = 4'b0001 << a; wdata = {4{st_data[7:0]}}.
  - Half: be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - Word: be = 4'b1111; wdata = st_data.
  - Any other mode value is treated as word.
- `st_ready` = (count != DEPTH). It is derived from registered state only and has no combinational path from `mem_ack` or `st_valid`.
- When full, `st_ready` is 0, so a store cannot be accepted in the same cycle as a pop. The slot becomes available in the next cycle.
- `mem_req` = (count != 0).
- When `mem_req` is 0, `mem_addr`, `mem_wdata` and `mem_be` are forced to 0.
- While `mem_req` is 1 and `mem_ack` is 0, all head outputs hold stable.
- Entries drain strictly in FIFO order. Entries are never merged or reordered.

## Timing
- Reset (asynchronous, immediate):
  - count = 0 and pointers = 0.
  - `mem_req`, `mem_be`, `mem_addr`, `mem_wdata`, `busy` and `st_misalign` = 0.
  - `st_ready` = 1.
- Reset mid-transaction: all queued entries are discarded, and `mem_req` falls immediately, with or without an outstanding ack.
- Latency from an accepted store into an empty buffer to `mem_req`/head outputs: 1 cycle, visible in the cycle after the accepting edge.
- With `mem_ack` held high, throughput is one write per cycle.
- `mem_ack` is sampled only while `mem_req` is 1. An ack while empty is ignored.
- `busy` = (count != 0).

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined:
  - A half store with `st_addr[0]` = 1, or a word store with `st_addr[1:0]` ≠ 0, still completes the handshake but is not enqueued.
  - `st_misalign` is registered and pulses high for exactly one cycle after the accepting edge.
- `STORE_MISALIGN_TRAP_EN` undefined:
  - Low address bits are ignored: half uses only `st_addr[1]`, and word ignores [1:0].
  - Every handshaked store is enqueued, and `st_misalign` is tied to 0.

## Test plan
- **Byte store:** sb at addr 0x1003, data 0x000000AB, `mem_ack` held low. Required: next cycle `mem_req`=1, `mem_addr`=0x1000, `mem_be`=4'b1000, `mem_wdata`=0xABABABAB. Outputs hold until ack.
- **Half store:** sh at 0x2002, data 0x1234CAFE. Required: `mem_be`=4'b1100, `mem_wdata`=0xCAFECAFE, `mem_addr`=0x2000.
- **Fill and drain (DEPTH=4):** push 4 words with `mem_ack`=0. Required: `count`=4 and `st_ready`=0; a 5th store stalls. Then ack for 4 cycles. Required: writes appear in order, and `st_ready`=1 in the cycle after the first pop.
- **Simultaneous push and pop at count 2:** push and ack in the same cycle. Required: `count` stays 2, and the head advances to the second entry.
- **Reset mid-drain:** assert `rst` with count 3 and `mem_req`=1. Required: `mem_req`, `mem_be` and `count` go to 0 without a clock edge; after release, `st_ready`=1.
- **Misaligned word:** sw at 0x3001. Required:
  - With `STORE_MISALIGN_TRAP_EN`: `st_misalign` pulses for 1 cycle and `count` is unchanged.
  - Without it: the store is enqueued with `mem_addr`=0x3000 and `mem_be`=4'b1111.
